// File: rtl/ram1p1rwbe_arb_pkg.sv
// Purpose: shared types and constants for the two-requester RAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package ram1p1rwbe_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    localparam int NREQ = 2;

    // One-hot grant vector for a requester index.
    function automatic logic [NREQ-1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram1p1rwbe_arb_rr_arb2.sv
// Purpose: two-way round-robin arbiter with a registered tie-break pointer.
// Latency: grant is combinational from req; pointer updates on the granting edge.
// Backpressure: no grant while en is low; losers must hold their request.
module rr_arb2
    import ram1p1rwbe_arb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic            ptr
);

    logic ptr_q;
    logic ptr_d;

    // Pick the sole requester, or the pointed-at one on contention; point away from the winner.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = idx_to_onehot(ptr_q);
                default: gnt = '0;
            endcase
            if (gnt != '0) begin
                ptr_d = ~gnt[1];
            end
        end
    end

    // Pointer register; starts by favouring requester 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/ram1p1rwbe_arb.sv
// Purpose: shares one read-first byte-enabled single-port RAM between two requesters, with init sweep.
// Latency: RAM pins combinational from grant; read data valid one cycle after grant.
// Backpressure: req_ready only for the granted requester; none during INIT or the init_req cycle.
module ram1p1rwbe_arb
    import ram1p1rwbe_arb_pkg::*;
#(
    parameter int                  DEPTH         = 64,
    parameter int                  WIDTH         = 44,
    parameter bit                  INIT_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0]    INIT_VALUE    = '0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  init_req,
    output logic                                  busy,
    input  logic [NREQ-1:0]                       req_valid,
    output logic [NREQ-1:0]                       req_ready,
    input  logic [NREQ-1:0]                       req_we,
    input  logic [NREQ*$clog2(DEPTH)-1:0]         req_addr,
    input  logic [NREQ*WIDTH-1:0]                 req_wdata,
    input  logic [NREQ*((WIDTH-1)/8+1)-1:0]       req_bwe,
    output logic [NREQ-1:0]                       rsp_valid,
    output logic [WIDTH-1:0]                      rsp_rdata,
    output logic                                  ram_ce,
    output logic                                  ram_we,
    output logic [$clog2(DEPTH)-1:0]              ram_addr,
    output logic [WIDTH-1:0]                      ram_din,
    output logic [(WIDTH-1)/8+1-1:0]              ram_bwe,
    input  logic [WIDTH-1:0]                      ram_dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (WIDTH - 1) / 8 + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    arb_state_t      state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0] gnt;
    logic            arb_en;
    logic            rr_ptr;
    logic            sel;

    // Arbitration only happens in RUN and never in the cycle an init sweep is requested.
    assign arb_en = (state_q == ST_RUN) && !init_req;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .en    (arb_en),
        .gnt   (gnt),
        .ptr   (rr_ptr)
    );

    assign sel = gnt[1];

    // Next-state, sweep counter, read-response tracking and RAM pin drive.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        ram_ce      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_din     = '0;
        ram_bwe     = '0;
        case (state_q)
            ST_INIT: begin
                ram_ce   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = cnt_q;
                ram_din  = INIT_VALUE;
                ram_bwe  = '1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else if (gnt != '0) begin
                    ram_ce   = 1'b1;
                    ram_we   = req_we[sel];
                    ram_addr = sel ? req_addr[2*AW-1:AW]       : req_addr[AW-1:0];
                    ram_din  = sel ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];
                    ram_bwe  = sel ? req_bwe[2*BW-1:BW]         : req_bwe[BW-1:0];
                    // Only reads return data, to the requester that issued them.
                    rsp_valid_d = req_we[sel] ? '0 : gnt;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, counter and response-valid registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign busy      = (state_q == ST_INIT);
    assign req_ready = gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = ram_dout;

    // After any grant the pointer must name the other requester.
    property p_ptr_follows_grant;
        @(posedge clk) disable iff (reset) (gnt != '0) |=> (rr_ptr == $past(gnt[0]));
    endproperty
    a_ptr_follows_grant: assert property (p_ptr_follows_grant);

endmodule

// File: tb/tb_ram1p1rwbe_arb.sv
module tb_ram1p1rwbe_arb;

    localparam int DEPTH = 64;
    localparam int WIDTH = 44;
    localparam int AW    = 6;
    localparam int BW    = 6;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  init_req;
    logic                  busy;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_we;
    logic [2*AW-1:0]       req_addr;
    logic [2*WIDTH-1:0]    req_wdata;
    logic [2*BW-1:0]       req_bwe;
    logic [1:0]            rsp_valid;
    logic [WIDTH-1:0]      rsp_rdata;
    logic                  ram_ce;
    logic                  ram_we;
    logic [AW-1:0]         ram_addr;
    logic [WIDTH-1:0]      ram_din;
    logic [BW-1:0]         ram_bwe;
    logic [WIDTH-1:0]      ram_dout;

    always #5 clk = ~clk;

    ram1p1rwbe_arb #(
        .DEPTH         (DEPTH),
        .WIDTH         (WIDTH),
        .INIT_ON_RESET (1'b1),
        .INIT_VALUE    ('0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .init_req  (init_req),
        .busy      (busy),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_bwe   (req_bwe),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_bwe   (ram_bwe),
        .ram_dout  (ram_dout)
    );

    // Read-first single-port RAM with registered read data.
    logic [WIDTH-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 44'hA5A_5A5A_5A5A;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_ce) begin
            ram_dout <= mem[ram_addr];
            if (ram_we) begin
                for (int k = 0; k < WIDTH; k++) begin
                    if (ram_bwe[k/8]) mem[ram_addr][k] <= ram_din[k];
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             idx;
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;
    exp_t sb[$];

    // Monitor: every response pops the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid != 2'b00) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected rsp_valid=%b rdata=%h cyc=%0d", rsp_valid, rsp_rdata, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_valid !== (e.idx ? 2'b10 : 2'b01) || rsp_rdata !== e.data || cyc != e.due) begin
                    failures++;
                    $display("FAIL rsp_check got valid=%b data=%h cyc=%0d expected valid=%b data=%h cyc=%0d",
                             rsp_valid, rsp_rdata, cyc, (e.idx ? 2'b10 : 2'b01), e.data, e.due);
                end
            end
        end
    end

    task automatic push_exp(input logic idx, input logic [WIDTH-1:0] d);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        e.due  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic set_slot(input int r, input logic we, input logic [AW-1:0] a,
                            input logic [WIDTH-1:0] d, input logic [BW-1:0] be);
        req_we[r]                 = we;
        req_addr[r*AW +: AW]      = a;
        req_wdata[r*WIDTH +: WIDTH] = d;
        req_bwe[r*BW +: BW]       = be;
    endtask

    // Single request from requester r; expectation pushed once the grant is seen.
    task automatic do_req(input int r, input logic we, input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d, input logic [BW-1:0] be,
                          input logic [WIDTH-1:0] exp_rd);
        bit granted = 0;
        set_slot(r, we, a, d, be);
        req_valid[r] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                granted = 1;
                break;
            end
        end
        checks++;
        if (!granted) begin
            failures++;
            $display("FAIL grant_timeout req=%0d ready=%b required grant", r, req_ready);
            req_valid[r] = 1'b0;
        end else begin
            if (!we) push_exp(r[0], exp_rd);
            @(posedge clk);
            #1 req_valid[r] = 1'b0;
        end
    endtask

    // Called at a negedge: check the expected grant, push read expectations, advance a cycle.
    task automatic grant_step(input logic [1:0] g, input logic [WIDTH-1:0] d0,
                              input logic [WIDTH-1:0] d1, input bit drop);
        checks++;
        if (req_ready !== g) begin
            failures++;
            $display("FAIL grant_order got=%b expected=%b cyc=%0d", req_ready, g, cyc);
        end
        if (g == 2'b01 && !req_we[0]) push_exp(1'b0, d0);
        if (g == 2'b10 && !req_we[1]) push_exp(1'b1, d1);
        @(posedge clk);
        #1;
        if (drop) req_valid = req_valid & ~g;
    endtask

    // Follow an INIT sweep cycle by cycle; requests are held valid to show they are not granted.
    task automatic check_sweep(input string name);
        int n = 0;
        bit ok = 1;
        logic [62:0] bad_got, bad_exp;
        logic [62:0] got, want;
        bad_got = '0;
        bad_exp = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
            got  = {ram_ce, ram_we, ram_addr, ram_bwe, ram_din, req_ready};
            want = {1'b1, 1'b1, 6'(n), 6'h3F, 44'h0, 2'b00};
            if (got !== want && ok) begin
                ok = 0;
                bad_got = got;
                bad_exp = want;
            end
            n++;
        end
        req_valid = 2'b00;
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL %s_busy_cycles got=%0d expected=%0d", name, n, DEPTH);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_sweep_pins got=%h expected=%h", name, bad_got, bad_exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        init_req  = 1'b0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        req_bwe   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_state rsp_valid=%b busy=%b expected rsp_valid=00 busy=1", rsp_valid, busy);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        // Initial sweep with both requesters asserting valid
        set_slot(0, 1'b0, 6'd3, '0, '0);
        set_slot(1, 1'b0, 6'd4, '0, '0);
        req_valid = 2'b11;
        check_sweep("init_reset");
        do_req(0, 1'b0, 6'd17, '0, '0, 44'h0);

        // Write by requester 0, read back by requester 1
        do_req(0, 1'b1, 6'd5, 44'h123_4567_89AB, 6'h3F, '0);
        do_req(1, 1'b0, 6'd5, '0, '0, 44'h123_4567_89AB);

        // Both requesters hold reads: grants alternate from requester 0
        do_req(0, 1'b1, 6'd1, 44'h111_2222_3333, 6'h3F, '0);
        do_req(1, 1'b1, 6'd2, 44'h444_5555_6666, 6'h3F, '0);
        set_slot(0, 1'b0, 6'd1, '0, '0);
        set_slot(1, 1'b0, 6'd2, '0, '0);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            grant_step((k % 2 == 0) ? 2'b01 : 2'b10, 44'h111_2222_3333, 44'h444_5555_6666, 1'b0);
        end
        req_valid = 2'b00;

        // Byte-enable write: only byte 1 is cleared
        do_req(0, 1'b1, 6'd9, 44'hFFF_FFFF_FFFF, 6'h3F, '0);
        do_req(0, 1'b1, 6'd9, 44'h0, 6'b000010, '0);
        do_req(0, 1'b0, 6'd9, '0, '0, 44'hFFF_FFFF_00FF);

        // Concurrent write (req 1, favoured) then same-address read (req 0) sees new data
        set_slot(1, 1'b1, 6'd7, 44'hABC_DEF0_1234, 6'h3F);
        set_slot(0, 1'b0, 6'd7, '0, '0);
        req_valid = 2'b11;
        @(negedge clk);
        grant_step(2'b10, '0, '0, 1'b1);
        @(negedge clk);
        grant_step(2'b01, 44'hABC_DEF0_1234, '0, 1'b1);

        // Read granted just before init_req still responds; init_req blocks grants that cycle
        do_req(0, 1'b0, 6'd7, '0, '0, 44'hABC_DEF0_1234);
        init_req = 1'b1;
        set_slot(0, 1'b0, 6'd5, '0, '0);
        set_slot(1, 1'b0, 6'd9, '0, '0);
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL init_req_cycle ready=%b busy=%b expected ready=00 busy=0", req_ready, busy);
        end
        @(posedge clk);
        #1 init_req = 1'b0;
        check_sweep("init_req");
        // Previously written addresses now hold INIT_VALUE; requester 1 is favoured
        req_valid = 2'b11;
        @(negedge clk);
        grant_step(2'b10, 44'h0, 44'h0, 1'b1);
        @(negedge clk);
        grant_step(2'b01, 44'h0, 44'h0, 1'b1);

        // Reset part way through a sweep restarts it from address 0
        init_req = 1'b1;
        @(posedge clk);
        #1 init_req = 1'b0;
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_addr !== 6'd30 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_sweep_addr got=%0d busy=%b expected addr=30 busy=1", ram_addr, busy);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        check_sweep("reset_restart");
        // Pointer was reset: requester 0 wins contention; sweep cleared address 1 and 7
        set_slot(0, 1'b0, 6'd1, '0, '0);
        set_slot(1, 1'b0, 6'd7, '0, '0);
        req_valid = 2'b11;
        @(negedge clk);
        grant_step(2'b01, 44'h0, 44'h0, 1'b1);
        @(negedge clk);
        grant_step(2'b10, 44'h0, 44'h0, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_responses outstanding=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram1p1rwbe_arb.md
Name: ram1p1rwbe_arb

Overview:
- Shares one single-port, byte-write-enabled RAM (ram1p1rwbe instance, read-first, registered address) between two requesters.
- Uses round-robin arbitration over per-requester valid/ready request ports.
- Runs an initialisation sweep that writes INIT_VALUE to every entry after reset or on demand.
- Sits between cache/boot logic and the storage array. Owns the RAM's ce/we/addr/din/bwe pins and routes read data back to the requester that issued the read.

Parameters:
- DEPTH, 64, number of RAM entries.
- WIDTH, 44, RAM word width in bits.
- INIT_ON_RESET, 1, 1 = enter INIT after reset; 0 = enter RUN directly.
- INIT_VALUE, '0, WIDTH-bit value written to every entry during INIT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- init_req  in  1  request a full-array initialisation sweep.
- busy  out  1  high while in INIT.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester grant; the transfer happens when valid & ready.
- req_we  in  2  per-requester write (1) / read (0).
- req_addr  in  2*$clog2(DEPTH)  packed addresses; requester i uses slice i.
- req_wdata  in  2*WIDTH  packed write data.
- req_bwe  in  2*((WIDTH-1)/8+1)  packed byte write enables.
- rsp_valid  out  2  one-cycle read-data-valid pulse, per requester.
- rsp_rdata  out  WIDTH  read data; equals ram_dout.
- ram_ce, ram_we  out  1  RAM chip enable and write enable.
- ram_addr  out  $clog2(DEPTH)  RAM address.
- ram_din  out  WIDTH  RAM write data.
- ram_bwe  out  (WIDTH-1)/8+1  RAM byte write enables.
- ram_dout  in  WIDTH  RAM read data, valid the cycle after ce.

Behaviour:
- States are INIT and RUN. Reset sets:
  - state = INIT if INIT_ON_RESET, else RUN;
  - sweep counter = 0;
  - rr_ptr = 0;
  - rsp_valid = 0.
- All RAM-side outputs are combinational from state and grant. When idle: ram_ce = 0, ram_we = 0, ram_bwe = 0.
- INIT:
  - Every cycle drives ce = 1, we = 1, addr = counter, din = INIT_VALUE, bwe = all ones.
  - Counter increments; after writing DEPTH-1, the next state is RUN and the counter returns to 0.
  - Takes exactly DEPTH cycles. busy = 1 and req_ready = 0 throughout.
  - init_req is ignored during INIT.
- RUN:
  - Grant goes to the sole valid requester. If both are valid, grant goes to requester rr_ptr.
  - On any grant, rr_ptr <= ~granted_index.
  - req_ready is combinational and is asserted only for the granted requester.
  - A granted request drives ce = 1, we = req_we, addr, din and bwe from that requester's slices.
- init_req in RUN:
  - No grant in that cycle (req_ready = 0).
  - Next state is INIT with counter = 0.
  - Any read granted in the previous cycle still produces its rsp_valid.
- Read latency is 1:
  - A read granted in cycle t gives rsp_valid[i] = 1 in cycle t+1, with rsp_rdata = ram_dout holding the pre-write contents.
  - Writes produce no response.
  - rsp_valid is never asserted for both requesters at once.
- The RAM keeps its registered address while ce = 0, so rsp_rdata stays stable until the next ce. Requesters must sample it on rsp_valid.
- Same-address read by one requester right after a write by the other returns the new data (ordered by grant).
- Reset mid-INIT restarts the sweep from 0 (or goes to RUN if INIT_ON_RESET = 0). Reset mid-read suppresses rsp_valid.
- Requests held low by a requester cause no state change. Ungranted requests must be held by the requester (no internal queueing).

Decomposition:
- Shared package: typedef arb_state_t {INIT, RUN} and localparam NREQ = 2.
- Sub-module rr_arb2: two-way round-robin arbiter.
  - Inputs: clk, reset, req[1:0], en.
  - Outputs: one-hot gnt[1:0] and the registered pointer.
  - en is low in INIT and during init_req.

Test Plan:
- Reset with INIT_ON_RESET = 1, DEPTH = 64, INIT_VALUE = 'h0 → busy high exactly 64 cycles, ram_addr sweeps 0..63 with bwe all ones, req_ready = 0 throughout, then a read of addr 17 returns 0.
- Requester 0 writes addr 5 = 'h123_4567_89AB with bwe = 6'b111111, then requester 1 reads addr 5 → rsp_valid = 2'b10 one cycle after grant, rsp_rdata = 'h123_4567_89AB.
- Both requesters hold valid reads continuously (addr 1 and addr 2) → grants alternate 0,1,0,1 starting from rr_ptr = 0, and rsp_valid alternates with matching data.
- Byte-enable write: addr 9 holds all ones, write 'h0 with bwe = 6'b000010 → read returns 'hFFF_FFFF_00FF.
- init_req in the same cycle as req_valid = 2'b11 → no grant that cycle, busy for 64 cycles, then requests are served, and reads of previously written addresses return INIT_VALUE.
- Reset asserted at sweep counter = 30 → the sweep restarts at addr 0 and busy lasts the full 64 cycles after reset deasserts.
